// File: rtl/pmu_ahb_slv.sv
// AHB-lite slave front end and register storage for the PMU register bank.
// Define PMU_AHB_ERR_EN to enable decode-error responses (ERR1/ERR2 states).
module pmu_ahb_slv #(
    parameter int                N_REGS      = 10,
    parameter int                WAIT_STATES = 0,
    parameter logic [N_REGS-1:0] RO_MASK     = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hsel_i,
    input  logic                   hreadyi_i,
    input  logic [31:0]            haddr_i,
    input  logic                   hwrite_i,
    input  logic [1:0]             htrans_i,
    input  logic [2:0]             hsize_i,
    input  logic [2:0]             hburst_i,
    input  logic [31:0]            hwdata_i,
    input  logic [3:0]             hprot_i,
    input  logic                   hmastlock_i,
    output logic                   hreadyo_o,
    output logic [1:0]             hresp_o,
    output logic [31:0]            hrdata_o,
    output logic [N_REGS*32-1:0]   regs_o,
    input  logic [N_REGS*32-1:0]   regs_i,
    output logic                   we_o
);

    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [IDX_W:0] NREG_L = (IDX_W+1)'(N_REGS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
    state_t state_q, state_d;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [1:0]              alo_q, alo_d;
    logic [2:0]              size_q, size_d;
    logic                    wr_q, wr_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [N_REGS-1:0][31:0] reg_q, reg_d, core_w;

    logic [IDX_W-1:0] idx_a;
    logic             accept, acc_err, in_range_q, ro_q, commit;
    logic [3:0]       lanes;
    logic [31:0]      lane_bits, rd_mux;
    logic             unused_ok;

    assign core_w    = regs_i;
    assign regs_o    = reg_q;
    assign idx_a     = haddr_i[IDX_W+1:2];
    assign accept    = hsel_i && hreadyi_i && htrans_i[1] && hreadyo_o;
    assign unused_ok = ^{hburst_i, hprot_i, hmastlock_i, haddr_i[31:IDX_W+2]};

`ifdef PMU_AHB_ERR_EN
    logic in_range_a, ro_a;
    always_comb begin
        ro_a = 1'b0;
        for (int i = 0; i < N_REGS; i++)
            if (idx_a == IDX_W'(i)) ro_a = RO_MASK[i];
        in_range_a = {1'b0, idx_a} < NREG_L;
        acc_err = !in_range_a || (hsize_i > 3'd2)
               || (hsize_i == 3'd1 && haddr_i[0])
               || (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00)
               || (hwrite_i && ro_a);
    end
`else
    assign acc_err = 1'b0;
`endif

    // Latched-index lookups; out-of-range indices read 0 and are never writable.
    always_comb begin
        ro_q   = 1'b0;
        rd_mux = '0;
        for (int i = 0; i < N_REGS; i++)
            if (idx_q == IDX_W'(i)) begin
                ro_q   = RO_MASK[i];
                rd_mux = reg_q[i];
            end
        in_range_q = {1'b0, idx_q} < NREG_L;
    end

    always_comb begin
        case (size_q)
            3'd0:    lanes = 4'b0001 << alo_q;
            3'd1:    lanes = alo_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
        lane_bits = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    end

    assign commit = (state_q == S_DATA) && wr_q && in_range_q && !ro_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: if (cnt_q == 3'd0) state_d = S_DATA;
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (!accept)     state_d = S_IDLE;
                else if (acc_err) state_d = S_ERR1;
                else             state_d = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            end
        endcase
    end

    always_comb begin
        hreadyo_o = !(state_q == S_WAIT || state_q == S_ERR1);
`ifdef PMU_AHB_ERR_EN
        hresp_o   = (state_q == S_ERR1 || state_q == S_ERR2) ? 2'b01 : 2'b00;
`else
        hresp_o   = 2'b00;
`endif
        hrdata_o  = (state_q == S_DATA && !wr_q) ? rd_mux : 32'h0;
        we_o      = commit;
    end

    // Core values flow in every cycle; a committing bus write overrides its lanes.
    always_comb begin
        idx_d  = accept ? idx_a : idx_q;
        alo_d  = accept ? haddr_i[1:0] : alo_q;
        size_d = accept ? hsize_i : size_q;
        wr_d   = accept ? hwrite_i : wr_q;
        if (accept)                 cnt_d = 3'(WAIT_STATES - 1);
        else if (state_q == S_WAIT) cnt_d = cnt_q - 3'd1;
        else                        cnt_d = cnt_q;
        reg_d = core_w;
        for (int i = 0; i < N_REGS; i++)
            if (commit && idx_q == IDX_W'(i))
                reg_d[i] = (core_w[i] & ~lane_bits) | (hwdata_i & lane_bits);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            alo_q  <= '0;
            size_q <= '0;
            wr_q   <= 1'b0;
            cnt_q  <= '0;
            reg_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            alo_q  <= alo_d;
            size_q <= size_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            reg_q  <= reg_d;
        end
    end

endmodule

// File: tb/tb_pmu_ahb_slv.sv
// Directed bench for pmu_ahb_slv: a zero-wait instance with reg 0 read-only
// and a 3-wait-state instance share the bus; expectations follow PMU_AHB_ERR_EN.
module tb_pmu_ahb_slv;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel0, sel1, hreadyi, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;

    logic        rdy0, rdy1, we0, we1;
    logic [1:0]  resp0, resp1;
    logic [31:0] rd0, rd1;
    logic [9:0][31:0] ro0, ri0, ro1;

    logic        loop0, ov_en;
    logic [31:0] ov_val;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        ri0 = loop0 ? ro0 : '0;
        if (ov_en) ri0[2] = ov_val;
    end

    pmu_ahb_slv #(.N_REGS(10), .WAIT_STATES(0), .RO_MASK(10'h001)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .hsel_i(sel0), .hreadyi_i(hreadyi),
        .haddr_i(haddr), .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize),
        .hburst_i(3'b000), .hwdata_i(hwdata), .hprot_i(4'b0011), .hmastlock_i(1'b0),
        .hreadyo_o(rdy0), .hresp_o(resp0), .hrdata_o(rd0),
        .regs_o(ro0), .regs_i(ri0), .we_o(we0));

    pmu_ahb_slv #(.N_REGS(10), .WAIT_STATES(3), .RO_MASK(10'h000)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .hsel_i(sel1), .hreadyi_i(hreadyi),
        .haddr_i(haddr), .hwrite_i(hwrite), .htrans_i(htrans), .hsize_i(hsize),
        .hburst_i(3'b000), .hwdata_i(hwdata), .hprot_i(4'b0011), .hmastlock_i(1'b0),
        .hreadyo_o(rdy1), .hresp_o(resp1), .hrdata_o(rd1),
        .regs_o(ro1), .regs_i(ro1), .we_o(we1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic addr(input int dut, input logic [31:0] a, input logic w, input logic [2:0] sz);
        sel0   = (dut == 0);
        sel1   = (dut == 1);
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle;
        sel0   = 1'b0;
        sel1   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        rst = 1'b1; hreadyi = 1'b1; hwdata = '0; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; loop0 = 1'b0; ov_en = 1'b0; ov_val = '0;
        idle();
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_rdy",  32'(rdy0),  32'd1);
        chk("rst_resp", 32'(resp0), 32'd0);
        chk("rst_rd",   rd0,        32'h0);
        chk("rst_we",   32'(we0),   32'd0);
        chk("rst_reg1", ro0[1],     32'h0);

        // word write then pipelined read, core holding 0
        addr(0, 32'h04, 1'b1, 3'd2); tick();
        hwdata = 32'hDEADBEEF; addr(0, 32'h04, 1'b0, 3'd2);
        chk("wr_we",  32'(we0),  32'd1);
        chk("wr_rdy", 32'(rdy0), 32'd1);
        tick(); idle();
        chk("wr_reg1",  ro0[1],     32'hDEADBEEF);
        chk("wr_we_lo", 32'(we0),   32'd0);
        chk("b2b_rd",   rd0,        32'hDEADBEEF);
        chk("b2b_resp", 32'(resp0), 32'd0);
        loop0 = 1'b1; tick();

        // byte write merged with a core update in the same cycle
        addr(0, 32'h0A, 1'b1, 3'd0); tick();
        hwdata = 32'h00AA0000; ov_val = 32'h11111111; ov_en = 1'b1; idle();
        tick(); ov_en = 1'b0;
        chk("byte_merge", ro0[2], 32'h11AA1111);

        // word then upper halfword
        addr(0, 32'h0C, 1'b1, 3'd2); tick();
        hwdata = 32'h12345678; addr(0, 32'h0E, 1'b1, 3'd1); tick();
        hwdata = 32'hABCD0000; idle();
        chk("word3", ro0[3], 32'h12345678);
        tick();
        chk("half3", ro0[3], 32'hABCD5678);

        // hreadyi low and BUSY must not start a data phase
        hreadyi = 1'b0; addr(0, 32'h0C, 1'b0, 3'd2); tick();
        hreadyi = 1'b1; idle();
        chk("hrdyi_blk", rd0, 32'h0);
        addr(0, 32'h0C, 1'b0, 3'd2); tick(); idle();
        chk("rd3", rd0, 32'hABCD5678);
        addr(0, 32'h0C, 1'b0, 3'd2); htrans = 2'b01; tick(); idle();
        chk("busy_blk", rd0, 32'h0);

        // write to read-only reg 0
        addr(0, 32'h00, 1'b1, 3'd2); tick();
        hwdata = 32'hFFFFFFFF; idle();
`ifdef PMU_AHB_ERR_EN
        chk("ro_e1_rdy",  32'(rdy0),  32'd0);
        chk("ro_e1_resp", 32'(resp0), 32'd1);
        tick();
        chk("ro_e2_rdy",  32'(rdy0),  32'd1);
        chk("ro_e2_resp", 32'(resp0), 32'd1);
        chk("ro_e2_we",   32'(we0),   32'd0);
`else
        chk("ro_rdy",  32'(rdy0),  32'd1);
        chk("ro_resp", 32'(resp0), 32'd0);
        chk("ro_we",   32'(we0),   32'd0);
`endif
        tick();
        chk("ro_reg0", ro0[0], 32'h0);

        // out-of-range read at index 10
        addr(0, 32'h28, 1'b0, 3'd2); tick(); idle();
`ifdef PMU_AHB_ERR_EN
        chk("oor_e1_rdy",  32'(rdy0),  32'd0);
        chk("oor_e1_resp", 32'(resp0), 32'd1);
        chk("oor_e1_rd",   rd0,        32'h0);
        tick();
        chk("oor_e2_rdy",  32'(rdy0),  32'd1);
        chk("oor_e2_resp", 32'(resp0), 32'd1);
        chk("oor_e2_rd",   rd0,        32'h0);
`else
        chk("oor_rdy",  32'(rdy0),  32'd1);
        chk("oor_resp", 32'(resp0), 32'd0);
        chk("oor_rd",   rd0,        32'h0);
`endif
        tick();

        // misaligned word read of 0x0E
        addr(0, 32'h0E, 1'b0, 3'd2); tick(); idle();
`ifdef PMU_AHB_ERR_EN
        chk("mis_rdy",  32'(rdy0),  32'd0);
        chk("mis_resp", 32'(resp0), 32'd1);
        tick();
`else
        chk("mis_rd", rd0, 32'hABCD5678);
`endif
        tick();

        // hsize=3 write to reg 4
        addr(0, 32'h10, 1'b1, 3'd3); tick();
        hwdata = 32'h55667788; idle();
`ifdef PMU_AHB_ERR_EN
        tick(); tick();
        chk("sz3_reg4", ro0[4], 32'h0);
`else
        tick();
        chk("sz3_reg4", ro0[4], 32'h55667788);
`endif

        // 3 wait states: write then pipelined reads
        addr(1, 32'h14, 1'b1, 3'd2); tick(); idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws_wr_lo%0d", k), 32'(rdy1), 32'd0);
            tick();
        end
        chk("ws_wr_rdy", 32'(rdy1), 32'd1);
        chk("ws_wr_we",  32'(we1),  32'd1);
        hwdata = 32'hCAFEF00D; addr(1, 32'h14, 1'b0, 3'd2);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ws_rd_lo%0d", k), 32'(rdy1), 32'd0);
            chk($sformatf("ws_rd_z%0d", k),  rd1,        32'h0);
            tick();
        end
        chk("ws_rd_rdy",  32'(rdy1),  32'd1);
        chk("ws_rd_data", rd1,        32'hCAFEF00D);
        chk("ws_rd_resp", 32'(resp1), 32'd0);
        addr(1, 32'h14, 1'b0, 3'd2); tick(); idle();
        chk("ws_pipe_acc", 32'(rdy1), 32'd0);

        // reset during a wait cycle
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_rdy",  32'(rdy1),  32'd1);
        chk("mrst_resp", 32'(resp1), 32'd0);
        chk("mrst_we",   32'(we1),   32'd0);
        chk("mrst_reg5", ro1[5],     32'h0);
        chk("mrst_reg3", ro0[3],     32'h0);
        tick();
        chk("mrst_idle", 32'(rdy1), 32'd1);
        chk("mrst_rd",   rd1,       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
